mrx_line_unpack: RTL and testbench
==================================

# mrx_line_unpack

Receive-side counterpart of the MIPI TX line packer. Accepts 64-bit MIPI RX payload words on the MIPI receive clock and buffers each line in a ping-pong line memory. Unpacks each word into four 8-bit luma samples plus chroma and replays the line as a 10-bit pixel stream with regenerated sync on the pixel clock. Sits between the MIPI RX core and the video input path (ISP/sync block).

## Interface
Parameters:
- `WORD_DEPTH`, 480: maximum 64-bit words per line; each bank holds this many words; memory depth = 2*WORD_DEPTH.
- `AW`, 10: memory address width; must satisfy 2^AW ≥ 2*WORD_DEPTH.

Ports:
- `MRCK` in 1: MIPI RX clock; write domain.
- `PCK` in 1: pixel clock; read/output domain.
- `RSTN` in 1: reset, asynchronous, active-low.
- `MRX_ON` in 1: enable, quasi-static; 0 forces all outputs to their reset values and both FSMs to idle.
- `MRX_HW` in 9: expected words per line, 1..WORD_DEPTH, quasi-static.
- `OVF_CLR` in 1: PCK-domain pulse; clears `LINE_DROP` and `LEN_ERR`.
- `iMIPI_RX0_VSYNC` in 1: frame window, level.
- `iMIPI_RX0_HSYNC` in 1: line window, level.
- `iMIPI_RX0_VALID` in 1: payload word qualifier.
- `iMIPI_RX0_DATA` in 64: payload word.
- `DO` out 10: pixel luma, `{byte, 2'b00}`.
- `DO_C` out 8: pixel chroma byte.
- `DO_ACT` out 1: pixel valid.
- `DO_HS` out 1: one-cycle line-start strobe.
- `DO_VS` out 1: synchronized frame level.
- `LINE_DROP` out 1: sticky; a line was dropped because the reader was busy.
- `LEN_ERR` out 1: sticky; received word count ≠ `MRX_HW`.

## Operation
- Word layout:
  - Pixel0 = DATA[15:8], chroma0 = DATA[7:0].
  - Pixel1 = DATA[31:24], chroma1 = DATA[23:16].
  - Pixel2 = DATA[47:40], chroma2 = DATA[39:32].
  - Pixel3 = DATA[63:56], chroma3 = DATA[55:48].
  - Pixel0 is the oldest pixel.
- Write FSM (MRCK), states:
  - IDLE: go to LINE on HSYNC rising while VSYNC=1.
  - LINE: each cycle with VALID=1 writes DATA at `WBANK*WORD_DEPTH + WCNT`, then WCNT+1.
    - Words with WCNT ≥ MRX_HW are discarded and not written; WCNT saturates.
  - On HSYNC falling:
    - If WCNT ≠ MRX_HW, set the LEN_ERR request.
    - Latch WBANK into the handoff register, toggle WBANK, toggle `LRDY_T`, clear WCNT, go to IDLE.
  - A line with zero VALID words still hands off and flags a length error.
- CDC:
  - `LRDY_T` toggle and VSYNC pass through 2-FF synchronizers into PCK.
  - A third flop plus XOR gives the `LINE_GO` pulse.
  - The handoff bank is read only on `LINE_GO`; it is stable by then.
  - The LEN_ERR request is carried as a toggle alongside `LRDY_T`.
- Read FSM (PCK), states:
  - IDLE: on `LINE_GO`, load RBANK, set RA=0, PH=0, go to RD.
  - RD:
    - PH counts 0..3; RA increments when PH=3.
    - Leave to IDLE after RA=MRX_HW-1, PH=3.
    - `LINE_GO` while in RD: line is dropped, LINE_DROP set, read continues uninterrupted.
- Sync output:
  - `DO_VS` = synchronized VSYNC.
  - VSYNC falling in PCK while in RD: the read completes; no truncation.
- Unpack: PH selects the byte lane (0→pixel0, …, 3→pixel3).
- Sticky flags:
  - `OVF_CLR` clears both flags.
  - If a set event and `OVF_CLR` occur in the same cycle, the set wins.

## Timing
- Reset and `MRX_ON`=0 values:
  - DO=0, DO_C=8'h80, DO_ACT=0, DO_HS=0, DO_VS=0, LINE_DROP=0, LEN_ERR=0.
  - WBANK=0, WCNT=0, both FSMs IDLE.
- Memory: two-port SRAM, 1-cycle registered read.
- Cycle t = `LINE_GO`:
  - t+1: `DO_HS`=1 for one cycle.
  - t+2: first `DO_ACT`=1 with pixel0 of word 0.
  - `DO_ACT` stays high for exactly 4*MRX_HW consecutive cycles.
- MRCK HSYNC fall to `LINE_GO`: 3–4 PCK cycles.
- Throughput: PCK rate ≥ 4 × average word rate is required; a violation appears as LINE_DROP.
- Reset mid-line: both sides return to IDLE asynchronously; the partial line is never output.

## Configuration
- `MRX_CHROMA_EN`:
  - Defined: `DO_C` carries the chroma byte of the current pixel, aligned with `DO`.
  - Undefined: `DO_C` is constant 8'h80, and chroma bits [7:0],[23:16],[39:32],[55:48] are not stored. The memory word narrows to 32 bits.

## Test plan
- Line data: MRX_HW=4, VSYNC=1, one line of words 64'h44_80_33_80_22_80_11_80 repeated 4× → DO_HS one cycle, then 16 DO_ACT cycles with DO = 11,22,33,44 (×4), each `<<2`. With the macro defined, DO_C=8'h80 throughout. LEN_ERR stays 0.
- Bank alternation: three back-to-back lines with distinct patterns → three bursts in order, banks alternate 0,1,0, no LINE_DROP.
- Short and long lines: MRX_HW=4; send 3 words, then 6 words → LEN_ERR=1 after the first line. The second line outputs only its first 4 words. OVF_CLR clears LEN_ERR.
- Reader busy: PCK slowed so a new line completes while RD is still active → LINE_DROP=1, the current burst completes intact, and the dropped line is not output.
- Reset mid-burst: assert RSTN low during DO_ACT → all outputs take reset values immediately. After release, the next full line outputs correctly.
- Enable off: `MRX_ON`=0 with traffic present → DO_ACT, DO_HS and DO_VS stay 0 and no flags are set.

Source files
------------

// File: rtl/mrx_line_unpack.sv
// MIPI RX line unpacker: buffers payload lines in a ping-pong memory on MRCK and replays
// them as a 10-bit pixel stream with regenerated sync on PCK. Define MRX_CHROMA_EN to carry chroma.
module mrx_line_unpack #(
  parameter int unsigned WORD_DEPTH = 480,
  parameter int unsigned AW         = 10
) (
  input  logic        MRCK,
  input  logic        PCK,
  input  logic        RSTN,
  input  logic        MRX_ON,
  input  logic [8:0]  MRX_HW,
  input  logic        OVF_CLR,
  input  logic        iMIPI_RX0_VSYNC,
  input  logic        iMIPI_RX0_HSYNC,
  input  logic        iMIPI_RX0_VALID,
  input  logic [63:0] iMIPI_RX0_DATA,
  output logic [9:0]  DO,
  output logic [7:0]  DO_C,
  output logic        DO_ACT,
  output logic        DO_HS,
  output logic        DO_VS,
  output logic        LINE_DROP,
  output logic        LEN_ERR
);

  localparam int unsigned CW        = 9;
  localparam int unsigned MEM_DEPTH = 2 * WORD_DEPTH;
`ifdef MRX_CHROMA_EN
  localparam int unsigned MW = 64;
`else
  localparam int unsigned MW = 32;
`endif

  typedef enum logic {W_IDLE, W_LINE} wstate_e;
  typedef enum logic {R_IDLE, R_RD}   rstate_e;

  // ---------------- write side (MRCK) ----------------
  wstate_e         r_wstate, w_wstate_nxt;
  logic [CW-1:0]   r_wcnt, w_wcnt_nxt;
  logic            r_wbank, w_wbank_nxt;
  logic            r_hbank, w_hbank_nxt;
  logic            r_lrdy_t, w_lrdy_t_nxt;
  logic            r_lerr_t, w_lerr_t_nxt;
  logic            r_hs_d;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [MW-1:0]   w_wdata;
  logic [MW-1:0]   r_mem [MEM_DEPTH];

  always_ff @(posedge MRCK or negedge RSTN) begin
    if (!RSTN) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_wbank  <= 1'b0;
      r_hbank  <= 1'b0;
      r_lrdy_t <= 1'b0;
      r_lerr_t <= 1'b0;
      r_hs_d   <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_wbank  <= w_wbank_nxt;
      r_hbank  <= w_hbank_nxt;
      r_lrdy_t <= w_lrdy_t_nxt;
      r_lerr_t <= w_lerr_t_nxt;
      r_hs_d   <= iMIPI_RX0_HSYNC;
    end
  end

  // Count runs one past MRX_HW so an over-long line still reads as a length error.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wcnt_nxt   = r_wcnt;
    w_wbank_nxt  = r_wbank;
    w_hbank_nxt  = r_hbank;
    w_lrdy_t_nxt = r_lrdy_t;
    w_lerr_t_nxt = r_lerr_t;
    w_we         = 1'b0;
    if (!MRX_ON) begin
      w_wstate_nxt = W_IDLE;
      w_wcnt_nxt   = '0;
      w_wbank_nxt  = 1'b0;
      w_hbank_nxt  = 1'b0;
      w_lrdy_t_nxt = 1'b0;
      w_lerr_t_nxt = 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (iMIPI_RX0_VSYNC && iMIPI_RX0_HSYNC && !r_hs_d) begin
            w_wstate_nxt = W_LINE;
            w_wcnt_nxt   = '0;
          end
        end
        W_LINE: begin
          if (!iMIPI_RX0_HSYNC) begin
            if (r_wcnt != MRX_HW) w_lerr_t_nxt = ~r_lerr_t;
            w_hbank_nxt  = r_wbank;
            w_wbank_nxt  = ~r_wbank;
            w_lrdy_t_nxt = ~r_lrdy_t;
            w_wcnt_nxt   = '0;
            w_wstate_nxt = W_IDLE;
          end else if (iMIPI_RX0_VALID && (r_wcnt <= MRX_HW)) begin
            w_we       = (r_wcnt < MRX_HW);
            w_wcnt_nxt = r_wcnt + CW'(1);
          end
        end
        default: w_wstate_nxt = W_IDLE;
      endcase
    end
  end

  assign w_waddr = r_wbank ? (AW'(WORD_DEPTH) + AW'(r_wcnt)) : AW'(r_wcnt);

`ifdef MRX_CHROMA_EN
  assign w_wdata = iMIPI_RX0_DATA;
`else
  logic w_unused_chroma;
  assign w_wdata = {iMIPI_RX0_DATA[63:56], iMIPI_RX0_DATA[47:40],
                    iMIPI_RX0_DATA[31:24], iMIPI_RX0_DATA[15:8]};
  assign w_unused_chroma = ^{iMIPI_RX0_DATA[55:48], iMIPI_RX0_DATA[39:32],
                             iMIPI_RX0_DATA[23:16], iMIPI_RX0_DATA[7:0]};
`endif

  always_ff @(posedge MRCK) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // ---------------- clock crossing into PCK ----------------
  logic [2:0] r_lrdy_s;
  logic [2:0] r_lerr_s;
  logic [1:0] r_vs_s;
  logic       w_line_go;
  logic       w_lerr_go;

  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      r_lrdy_s <= '0;
      r_lerr_s <= '0;
      r_vs_s   <= '0;
    end else if (!MRX_ON) begin
      r_lrdy_s <= '0;
      r_lerr_s <= '0;
      r_vs_s   <= '0;
    end else begin
      r_lrdy_s <= {r_lrdy_s[1:0], r_lrdy_t};
      r_lerr_s <= {r_lerr_s[1:0], r_lerr_t};
      r_vs_s   <= {r_vs_s[0], iMIPI_RX0_VSYNC};
    end
  end

  assign w_line_go = r_lrdy_s[2] ^ r_lrdy_s[1];
  assign w_lerr_go = r_lerr_s[2] ^ r_lerr_s[1];

  // ---------------- read side (PCK) ----------------
  rstate_e       r_rstate, w_rstate_nxt;
  logic          r_rbank, w_rbank_nxt;
  logic [CW-1:0] r_ra, w_ra_nxt;
  logic [1:0]    r_ph, w_ph_nxt;
  logic          w_act_nxt, w_hs_nxt, w_drop_set;
  logic [AW-1:0] w_raddr;
  logic [MW-1:0] r_rdata;
  logic [7:0]    w_luma, w_chroma;
  logic [9:0]    r_do;
  logic [7:0]    r_do_c;
  logic          r_do_act, r_do_hs, r_do_vs, r_line_drop, r_len_err;

  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      r_rstate <= R_IDLE;
      r_rbank  <= 1'b0;
      r_ra     <= '0;
      r_ph     <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_rbank  <= w_rbank_nxt;
      r_ra     <= w_ra_nxt;
      r_ph     <= w_ph_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rbank_nxt  = r_rbank;
    w_ra_nxt     = r_ra;
    w_ph_nxt     = r_ph;
    w_act_nxt    = 1'b0;
    w_hs_nxt     = 1'b0;
    w_drop_set   = 1'b0;
    if (!MRX_ON) begin
      w_rstate_nxt = R_IDLE;
      w_rbank_nxt  = 1'b0;
      w_ra_nxt     = '0;
      w_ph_nxt     = '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_line_go) begin
            w_rstate_nxt = R_RD;
            w_rbank_nxt  = r_hbank;
            w_ra_nxt     = '0;
            w_ph_nxt     = '0;
            w_hs_nxt     = 1'b1;
          end
        end
        R_RD: begin
          w_act_nxt  = 1'b1;
          w_drop_set = w_line_go;
          if (r_ph == 2'd3) begin
            w_ph_nxt = '0;
            if (r_ra == (MRX_HW - CW'(1))) w_rstate_nxt = R_IDLE;
            else                           w_ra_nxt     = r_ra + CW'(1);
          end else begin
            w_ph_nxt = r_ph + 2'd1;
          end
        end
        default: w_rstate_nxt = R_IDLE;
      endcase
    end
  end

  // Address follows next-state so the registered read lands with the matching phase.
  assign w_raddr = w_rbank_nxt ? (AW'(WORD_DEPTH) + AW'(w_ra_nxt)) : AW'(w_ra_nxt);

  always_ff @(posedge PCK) begin
    r_rdata <= r_mem[w_raddr];
  end

  always_comb begin
    w_luma   = '0;
    w_chroma = 8'h80;
`ifdef MRX_CHROMA_EN
    case (r_ph)
      2'd0:    begin w_luma = r_rdata[15:8];  w_chroma = r_rdata[7:0];   end
      2'd1:    begin w_luma = r_rdata[31:24]; w_chroma = r_rdata[23:16]; end
      2'd2:    begin w_luma = r_rdata[47:40]; w_chroma = r_rdata[39:32]; end
      default: begin w_luma = r_rdata[63:56]; w_chroma = r_rdata[55:48]; end
    endcase
`else
    case (r_ph)
      2'd0:    w_luma = r_rdata[7:0];
      2'd1:    w_luma = r_rdata[15:8];
      2'd2:    w_luma = r_rdata[23:16];
      default: w_luma = r_rdata[31:24];
    endcase
`endif
  end

  // Sticky flags: a set event in the same cycle as OVF_CLR wins.
  always_ff @(posedge PCK or negedge RSTN) begin
    if (!RSTN) begin
      r_do        <= '0;
      r_do_c      <= 8'h80;
      r_do_act    <= 1'b0;
      r_do_hs     <= 1'b0;
      r_do_vs     <= 1'b0;
      r_line_drop <= 1'b0;
      r_len_err   <= 1'b0;
    end else if (!MRX_ON) begin
      r_do        <= '0;
      r_do_c      <= 8'h80;
      r_do_act    <= 1'b0;
      r_do_hs     <= 1'b0;
      r_do_vs     <= 1'b0;
      r_line_drop <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_do        <= w_act_nxt ? {w_luma, 2'b00} : 10'd0;
      r_do_c      <= w_act_nxt ? w_chroma : 8'h80;
      r_do_act    <= w_act_nxt;
      r_do_hs     <= w_hs_nxt;
      r_do_vs     <= r_vs_s[1];
      r_line_drop <= w_drop_set | (r_line_drop & ~OVF_CLR);
      r_len_err   <= w_lerr_go  | (r_len_err & ~OVF_CLR);
    end
  end

  assign DO        = r_do;
  assign DO_C      = r_do_c;
  assign DO_ACT    = r_do_act;
  assign DO_HS     = r_do_hs;
  assign DO_VS     = r_do_vs;
  assign LINE_DROP = r_line_drop;
  assign LEN_ERR   = r_len_err;

endmodule

// File: tb/tb_mrx_line_unpack.sv
// Scoreboard bench for mrx_line_unpack: random lines against a bank-level memory model,
// with a decoupled pixel monitor on PCK.
module tb_mrx_line_unpack;

  logic        MRCK, PCK, RSTN, MRX_ON, OVF_CLR;
  logic [8:0]  MRX_HW;
  logic        vs, hs, valid;
  logic [63:0] data;
  logic [9:0]  DO;
  logic [7:0]  DO_C;
  logic        DO_ACT, DO_HS, DO_VS, LINE_DROP, LEN_ERR;

  int checks   = 0;
  int failures = 0;
  int pck_half = 2;

  logic [17:0] exp_q[$];
  int          exp_len_q[$];
  logic [63:0] mmem [2][64];
  logic [63:0] lw [64];
  int          hw;
  bit          m_bank, m_on, exp_len_err, exp_drop;

  mrx_line_unpack dut (
    .MRCK(MRCK), .PCK(PCK), .RSTN(RSTN), .MRX_ON(MRX_ON), .MRX_HW(MRX_HW),
    .OVF_CLR(OVF_CLR), .iMIPI_RX0_VSYNC(vs), .iMIPI_RX0_HSYNC(hs),
    .iMIPI_RX0_VALID(valid), .iMIPI_RX0_DATA(data),
    .DO(DO), .DO_C(DO_C), .DO_ACT(DO_ACT), .DO_HS(DO_HS), .DO_VS(DO_VS),
    .LINE_DROP(LINE_DROP), .LEN_ERR(LEN_ERR)
  );

  initial begin MRCK = 1'b0; forever #10 MRCK = ~MRCK; end
  initial begin PCK  = 1'b0; forever #(pck_half) PCK = ~PCK; end

  initial begin
    #3000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected pixels/burst lengths whenever the DUT presents output.
  int act_cnt = 0, cur_len = 0;
  bit prev_hs = 1'b0, prev_act = 1'b0;
  always @(negedge PCK) begin
    if (!RSTN) begin
      exp_q.delete();
      exp_len_q.delete();
      act_cnt  = 0;
      prev_hs  = 1'b0;
      prev_act = 1'b0;
    end else begin
      if (prev_act && !DO_ACT) begin
        chk("burst_len", 32'(act_cnt), 32'(cur_len));
        act_cnt = 0;
      end
      if (DO_HS) begin
        chk("hs_width", 32'(prev_hs), 32'(0));
        chk("hs_expected", 32'(exp_len_q.size() != 0), 32'(1));
        if (exp_len_q.size() != 0) cur_len = exp_len_q.pop_front();
      end
      if (DO_ACT) begin
        if (!prev_act) chk("act_after_hs", 32'(prev_hs), 32'(1));
        act_cnt++;
        chk("pixel_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) chk("pixel", 32'({DO, DO_C}), 32'(exp_q.pop_front()));
      end
      prev_hs  = DO_HS;
      prev_act = DO_ACT;
    end
  end

  task automatic set_hw(input int h);
    hw     = h;
    MRX_HW = 9'(h);
  endtask

  task automatic fill_rand(input int n);
    for (int w = 0; w < n; w++) lw[w] = {$urandom, $urandom};
  endtask

  // Drives one line and updates the bank model; expected pixels are queued before handoff.
  task automatic send_line(input int n, input bit expect_out, input int gap_max);
    logic [63:0] wd;
    logic [7:0]  ch;
    @(posedge MRCK); #1;
    hs = 1'b1; valid = 1'b0;
    @(posedge MRCK); #1;
    for (int w = 0; w < n; w++) begin
      valid = 1'b0;
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin @(posedge MRCK); #1; end
      valid = 1'b1; data = lw[w];
      @(posedge MRCK); #1;
    end
    valid = 1'b0;
    if (m_on) begin
      for (int w = 0; w < n && w < hw; w++) mmem[m_bank][w] = lw[w];
      if (n != hw) exp_len_err = 1'b1;
      if (expect_out) begin
        for (int w = 0; w < hw; w++) begin
          wd = mmem[m_bank][w];
          for (int ln = 0; ln < 4; ln++) begin
`ifdef MRX_CHROMA_EN
            ch = wd[ln*16 +: 8];
`else
            ch = 8'h80;
`endif
            exp_q.push_back({wd[ln*16+8 +: 8], 2'b00, ch});
          end
        end
        exp_len_q.push_back(4 * hw);
      end else begin
        exp_drop = 1'b1;
      end
      m_bank = ~m_bank;
    end
    hs = 1'b0;
    repeat (3) begin @(posedge MRCK); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_len_q.size() != 0) && n < 5000) begin
      @(negedge PCK);
      n++;
    end
    chk("drain_done", 32'(n < 5000), 32'(1));
    repeat (10) @(negedge PCK);
  endtask

  task automatic check_flags();
    chk("len_err", 32'(LEN_ERR), 32'(exp_len_err));
    chk("line_drop", 32'(LINE_DROP), 32'(exp_drop));
  endtask

  task automatic ovf_clr();
    @(negedge PCK); OVF_CLR = 1'b1;
    @(negedge PCK); OVF_CLR = 1'b0;
    exp_len_err = 1'b0;
    exp_drop    = 1'b0;
    repeat (2) @(negedge PCK);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_do"},     32'(DO),     32'(0));
    chk({tag, "_do_c"},   32'(DO_C),   32'(8'h80));
    chk({tag, "_do_act"}, 32'(DO_ACT), 32'(0));
    chk({tag, "_do_hs"},  32'(DO_HS),  32'(0));
    chk({tag, "_do_vs"},  32'(DO_VS),  32'(0));
  endtask

  initial begin
    int n;
    RSTN = 1'b0; MRX_ON = 1'b1; OVF_CLR = 1'b0;
    vs = 1'b0; hs = 1'b0; valid = 1'b0; data = '0;
    m_bank = 1'b0; m_on = 1'b1; exp_len_err = 1'b0; exp_drop = 1'b0;
    for (int b = 0; b < 2; b++) for (int w = 0; w < 64; w++) mmem[b][w] = '0;
    set_hw(4);
    #45;
    check_idle_outputs("rst");
    check_flags();
    RSTN = 1'b1;
    repeat (3) @(posedge MRCK);
    #1 vs = 1'b1;

    // Fixed line pattern.
    for (int w = 0; w < 4; w++) lw[w] = 64'h44_80_33_80_22_80_11_80;
    send_line(4, 1'b1, 0);
    drain();
    check_flags();
    chk("do_vs", 32'(DO_VS), 32'(1));

    // Three back-to-back lines, distinct data.
    for (int l = 0; l < 3; l++) begin
      fill_rand(4);
      send_line(4, 1'b1, 0);
    end
    drain();
    check_flags();

    // Random line lengths and spacing.
    for (int l = 0; l < 8; l++) begin
      set_hw($urandom_range(16, 1));
      fill_rand(hw);
      send_line(hw, 1'b1, 3);
      drain();
    end
    check_flags();

    // Short then long line.
    set_hw(4);
    fill_rand(3);
    send_line(3, 1'b1, 2);
    drain();
    check_flags();
    ovf_clr();
    check_flags();
    fill_rand(6);
    send_line(6, 1'b1, 2);
    drain();
    check_flags();
    ovf_clr();
    check_flags();

    // Slow reader: second line completes while the first is still replaying.
    set_hw(8);
    pck_half = 25;
    fill_rand(8);
    send_line(8, 1'b1, 0);
    fill_rand(8);
    send_line(8, 1'b0, 0);
    drain();
    check_flags();
    pck_half = 2;
    repeat (4) @(negedge PCK);
    ovf_clr();
    check_flags();

    // Reset in the middle of a burst.
    set_hw(16);
    fill_rand(16);
    send_line(16, 1'b1, 0);
    n = 0;
    while (!DO_ACT && n < 500) begin @(negedge PCK); n++; end
    chk("burst_seen", 32'(DO_ACT), 32'(1));
    repeat (3) @(negedge PCK);
    #1 RSTN = 1'b0;
    #1;
    check_idle_outputs("midrst");
    m_bank = 1'b0; exp_len_err = 1'b0; exp_drop = 1'b0;
    repeat (4) @(negedge PCK);
    RSTN = 1'b1;
    repeat (4) @(posedge MRCK);
    fill_rand(16);
    send_line(16, 1'b1, 2);
    drain();
    check_flags();
    chk("do_vs_after_rst", 32'(DO_VS), 32'(1));

    // Enable off with traffic: nothing output, no flags.
    @(posedge MRCK); #1 MRX_ON = 1'b0;
    m_on = 1'b0; m_bank = 1'b0;
    repeat (4) @(posedge MRCK);
    fill_rand(2);
    send_line(2, 1'b1, 0);
    repeat (20) @(negedge PCK);
    check_idle_outputs("off");
    check_flags();
    @(posedge MRCK); #1 MRX_ON = 1'b1;
    m_on = 1'b1;
    repeat (4) @(posedge MRCK);
    fill_rand(16);
    send_line(16, 1'b1, 1);
    drain();
    check_flags();
    chk("do_vs_on", 32'(DO_VS), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
